// File: rtl/spi_master_pkg.sv
// Shared types and constants for the mode-0 SPI master: FSM state encoding
// and the position of the read/write select bit in the command word.
package spi_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int RW_BIT_POS_DEFAULT = 8;

    // Read/write select sits in the top bit of the command word.
    function automatic int rw_bit_pos(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/spi_master.sv
// Mode-0 SPI master: one command word per frame, SCK at half the system clock,
// MSB-first shifting, one-cycle done pulse per write or read frame.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int         WIDTH = 9,
    parameter logic [3:0] DEPTH = 4'd8
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_en,
    input  logic [WIDTH-1:0] I_data_in,
    input  logic             I_spi_miso,
    output logic [7:0]       O_data_out,
    output logic             O_tx_done,
    output logic             O_rx_done,
    output logic             O_spi_sck,
    output logic             O_spi_cs,
    output logic             O_spi_mosi
);

    localparam int         RW_POS   = rw_bit_pos(WIDTH);
    localparam logic [3:0] CNT_LAST = 4'((2 * int'(DEPTH)) - 1);

    state_t           r_state,    w_state_nxt;
    logic [3:0]       r_cnt,      w_cnt_nxt;
    logic [WIDTH-1:0] r_cmd,      w_cmd_nxt;
    logic [7:0]       r_shift,    w_shift_nxt;
    logic [7:0]       r_data_out, w_data_out_nxt;
    logic             r_tx_done,  w_tx_done_nxt;
    logic             r_rx_done,  w_rx_done_nxt;
    logic             r_sck,      w_sck_nxt;
    logic             r_cs,       w_cs_nxt;
    logic             r_mosi,     w_mosi_nxt;
    logic             w_rd;
    logic [3:0]       w_bit_idx;

    assign w_rd = r_cmd[RW_POS];
    // Leaving odd cnt c, the next bit to present is DEPTH-1-(c+1)/2.
    assign w_bit_idx = DEPTH - 4'd2 - {1'b0, r_cnt[3:1]};

    // Next-state and next-output logic; outputs are computed here and registered below.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cmd_nxt      = r_cmd;
        w_shift_nxt    = r_shift;
        w_data_out_nxt = r_data_out;
        w_tx_done_nxt  = 1'b0;
        w_rx_done_nxt  = 1'b0;
        w_sck_nxt      = 1'b0;
        w_cs_nxt       = 1'b1;
        w_mosi_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (I_en) begin
                    w_state_nxt = XFER;
                    w_cnt_nxt   = 4'd0;
                    w_cmd_nxt   = I_data_in;
                    w_shift_nxt = 8'd0;
                    w_cs_nxt    = 1'b0;
                    w_mosi_nxt  = I_data_in[RW_POS] ? 1'b0 : I_data_in[DEPTH - 4'd1];
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            XFER: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = 4'd0;
                    if (w_rd) begin
                        w_rx_done_nxt  = 1'b1;
                        w_data_out_nxt = {r_shift[6:0], I_spi_miso};
                    end else begin
                        w_tx_done_nxt = 1'b1;
                    end
                end else if (r_cnt[0]) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                    w_cs_nxt  = 1'b0;
                    if (w_rd) begin
                        w_shift_nxt = {r_shift[6:0], I_spi_miso};
                        w_mosi_nxt  = 1'b0;
                    end else begin
                        w_mosi_nxt  = r_cmd[w_bit_idx];
                    end
                end else begin
                    w_cnt_nxt  = r_cnt + 4'd1;
                    w_cs_nxt   = 1'b0;
                    w_sck_nxt  = 1'b1;
                    w_mosi_nxt = r_mosi;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State, counter, datapath and output registers with synchronous reset.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_cmd      <= '0;
            r_shift    <= 8'd0;
            r_data_out <= 8'd0;
            r_tx_done  <= 1'b0;
            r_rx_done  <= 1'b0;
            r_sck      <= 1'b0;
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cmd      <= w_cmd_nxt;
            r_shift    <= w_shift_nxt;
            r_data_out <= w_data_out_nxt;
            r_tx_done  <= w_tx_done_nxt;
            r_rx_done  <= w_rx_done_nxt;
            r_sck      <= w_sck_nxt;
            r_cs       <= w_cs_nxt;
            r_mosi     <= w_mosi_nxt;
        end
    end

    assign O_data_out = r_data_out;
    assign O_tx_done  = r_tx_done;
    assign O_rx_done  = r_rx_done;
    assign O_spi_sck  = r_sck;
    assign O_spi_cs   = r_cs;
    assign O_spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: waveform-queue reference model checked every
// cycle, directed frames with literal expectations, then randomized traffic.
module tb_spi_master;

    logic       I_clk;
    logic       I_rst;
    logic       I_en;
    logic [8:0] I_data_in;
    logic       I_spi_miso;
    logic [7:0] O_data_out;
    logic       O_tx_done;
    logic       O_rx_done;
    logic       O_spi_sck;
    logic       O_spi_cs;
    logic       O_spi_mosi;

    spi_master #(.WIDTH(9), .DEPTH(4'd8)) dut (
        .I_clk      (I_clk),
        .I_rst      (I_rst),
        .I_en       (I_en),
        .I_data_in  (I_data_in),
        .I_spi_miso (I_spi_miso),
        .O_data_out (O_data_out),
        .O_tx_done  (O_tx_done),
        .O_rx_done  (O_rx_done),
        .O_spi_sck  (O_spi_sck),
        .O_spi_cs   (O_spi_cs),
        .O_spi_mosi (O_spi_mosi)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    // One expected cycle of pin activity; miso is what the bench drives that cycle.
    typedef struct packed {
        logic       idle;
        logic       cs;
        logic       sck;
        logic       mosi;
        logic       tx;
        logic       rx;
        logic       miso;
        logic       ld;
        logic [7:0] dout;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    logic [7:0] exp_dout;
    bit         model_valid;
    int         n_checks;
    int         n_fail;

    logic       obs_cs, obs_sck, obs_mosi, obs_tx, obs_rx;
    logic [7:0] obs_dout;

    logic [15:0] res_bits;
    int          res_pulses, res_tx, res_rx, res_done_at, res_mosi_hi;
    logic        res_cs_after, res_sck_after;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t idle_t();
        exp_t t;
        t      = '0;
        t.idle = 1'b1;
        t.cs   = 1'b1;
        t.miso = 1'($urandom);
        return t;
    endfunction

    // A frame is 8 (SCK low, SCK high) pairs then one DONE cycle with CS high.
    task automatic build_frame(input logic [8:0] cmd, input logic [7:0] pat);
        exp_t t;
        logic rd;
        rd = cmd[8];
        for (int i = 0; i < 8; i++) begin
            t      = '0;
            t.mosi = rd ? 1'b0 : cmd[7 - i];
            t.miso = 1'($urandom);
            q.push_back(t);
            t.sck  = 1'b1;
            t.miso = pat[7 - i];
            q.push_back(t);
        end
        t      = '0;
        t.cs   = 1'b1;
        t.tx   = ~rd;
        t.rx   = rd;
        t.ld   = rd;
        t.dout = pat;
        t.miso = 1'($urandom);
        q.push_back(t);
    endtask

    task automatic model_step(input logic rst, input logic en, input logic [8:0] data,
                              input logic [7:0] pat);
        if (rst) begin
            q.delete();
            exp_dout    = 8'd0;
            cur         = idle_t();
            model_valid = 1'b1;
        end else begin
            if (cur.idle && en) build_frame(data, pat);
            if (q.size() > 0) cur = q.pop_front();
            else cur = idle_t();
            if (cur.ld) exp_dout = cur.dout;
        end
    endtask

    // One clock: observe outputs and drive inputs on the falling edge, step the model on the rising edge.
    task automatic cycle(input logic rst, input logic en, input logic [8:0] data,
                         input logic [7:0] pat);
        @(negedge I_clk);
        obs_cs     = O_spi_cs;
        obs_sck    = O_spi_sck;
        obs_mosi   = O_spi_mosi;
        obs_tx     = O_tx_done;
        obs_rx     = O_rx_done;
        obs_dout   = O_data_out;
        I_rst      = rst;
        I_en       = en;
        I_data_in  = data;
        I_spi_miso = cur.miso;
        @(posedge I_clk);
        model_step(rst, en, data, pat);
    endtask

    task automatic run_frame(input logic [8:0] data, input logic [7:0] pat,
                             input int busy_at, input int rst_at);
        logic prev_sck;
        prev_sck    = 1'b0;
        res_bits    = 16'd0;
        res_pulses  = 0;
        res_tx      = 0;
        res_rx      = 0;
        res_done_at = 0;
        res_mosi_hi = 0;
        cycle(1'b0, 1'b1, data, pat);
        for (int k = 1; k <= 22; k++) begin
            cycle(k == rst_at, k == busy_at, (k == busy_at) ? 9'h1FF : data, pat);
            if (obs_sck && !prev_sck) begin
                res_bits = {res_bits[14:0], obs_mosi};
                res_pulses++;
            end
            if (obs_tx) begin res_tx++; res_done_at = k; end
            if (obs_rx) begin res_rx++; res_done_at = k; end
            if (obs_mosi) res_mosi_hi++;
            if (k == rst_at + 1) begin
                res_cs_after  = obs_cs;
                res_sck_after = obs_sck;
            end
            prev_sck = obs_sck;
        end
    endtask

    // Every-cycle comparison of the DUT pins against the model's current cycle.
    always @(negedge I_clk) begin
        if (model_valid) begin
            check("cs",         O_spi_cs,               cur.cs);
            check("sck",        O_spi_sck,              cur.sck);
            check("mosi",       O_spi_mosi,             cur.mosi);
            check("tx_done",    O_tx_done,              cur.tx);
            check("rx_done",    O_rx_done,              cur.rx);
            check("data_out",   O_data_out,             exp_dout);
            check("tx_rx_excl", O_tx_done & O_rx_done,  1'b0);
        end
    end

    initial begin
        int idle_done, idle_cs_low, idle_sck_hi, cs_hi, tx_cnt;
        logic prev_sck;
        logic [15:0] bits;
        n_checks    = 0;
        n_fail      = 0;
        model_valid = 1'b0;
        cur         = idle_t();
        exp_dout    = 8'd0;
        I_rst       = 1'b1;
        I_en        = 1'b0;
        I_data_in   = 9'd0;
        I_spi_miso  = 1'b0;

        // Reset one cycle, then 500 quiet cycles.
        cycle(1'b1, 1'b0, 9'd0, 8'd0);
        idle_done = 0; idle_cs_low = 0; idle_sck_hi = 0;
        for (int i = 0; i < 500; i++) begin
            cycle(1'b0, 1'b0, 9'($urandom), 8'd0);
            if (i == 0) begin
                check("rst_cs",   obs_cs,   1'b1);
                check("rst_dout", obs_dout, 8'd0);
            end
            if (obs_tx || obs_rx) idle_done++;
            if (!obs_cs) idle_cs_low++;
            if (obs_sck) idle_sck_hi++;
        end
        check("idle_done",   idle_done,   0);
        check("idle_cs_low", idle_cs_low, 0);
        check("idle_sck_hi", idle_sck_hi, 0);

        // Write 0x0A5.
        run_frame(9'h0A5, 8'h00, 0, 0);
        check("wr_bits",    res_bits[7:0], 8'hA5);
        check("wr_pulses",  res_pulses,    8);
        check("wr_tx",      res_tx,        1);
        check("wr_rx",      res_rx,        0);
        check("wr_done_at", res_done_at,   17);
        check("wr_dout",    obs_dout,      8'h00);

        // Read with slave pattern 0x3C.
        run_frame(9'h100, 8'h3C, 0, 0);
        check("rd_dout",    obs_dout,    8'h3C);
        check("rd_rx",      res_rx,      1);
        check("rd_tx",      res_tx,      0);
        check("rd_mosi_hi", res_mosi_hi, 0);
        check("rd_pulses",  res_pulses,  8);
        check("rd_done_at", res_done_at, 17);

        // Start request with other data mid-frame is ignored.
        run_frame(9'h05A, 8'h00, 5, 0);
        check("busy_bits",  res_bits[7:0], 8'h5A);
        check("busy_tx",    res_tx,        1);
        check("busy_rx",    res_rx,        0);
        check("busy_pulse", res_pulses,    8);
        check("busy_dout",  obs_dout,      8'h3C);

        // Reset during a write, then a clean write of 0x03C.
        run_frame(9'h0FF, 8'h00, 0, 7);
        check("rst_cs_after",  res_cs_after,    1'b1);
        check("rst_sck_after", res_sck_after,   1'b0);
        check("rst_no_done",   res_tx + res_rx, 0);
        run_frame(9'h03C, 8'h00, 0, 0);
        check("post_rst_bits", res_bits[7:0], 8'h3C);
        check("post_rst_tx",   res_tx,        1);
        check("post_rst_done", res_done_at,   17);

        // Back-to-back writes with I_en held high; data changes after the first latch.
        prev_sck = 1'b0; bits = 16'd0; cs_hi = 0; tx_cnt = 0;
        cycle(1'b0, 1'b1, 9'h0C3, 8'h00);
        for (int k = 1; k <= 45; k++) begin
            cycle(1'b0, k <= 19, 9'h066, 8'h00);
            if (obs_sck && !prev_sck) bits = {bits[14:0], obs_mosi};
            if (k <= 34 && obs_cs) cs_hi++;
            if (obs_tx) tx_cnt++;
            prev_sck = obs_sck;
        end
        check("b2b_bits",  bits,   16'hC366);
        check("b2b_cs_hi", cs_hi,  2);
        check("b2b_tx",    tx_cnt, 2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                  9'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
